// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the default frame start byte.
// Latency: n/a (types and constants only). Backpressure: n/a.
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } loadState_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/im_word_packer.sv
// Packs accepted bytes MSB-first into a 32-bit word and keeps the frame's running XOR.
// Latency: a byte is in the word/checksum one edge after shiftEn; lastByte is registered-state decode.
// Backpressure: none of its own; the loader decides when a byte is accepted (shiftEn).
// Ports: Clk/Reset (async active-low); clear restarts byte count and checksum for a new
// frame; shiftEn+byteIn push one byte; word/checksum are the packed state; lastByte
// flags that the next shifted byte completes the current word.
module im_word_packer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        clear,
  input  logic        shiftEn,
  input  logic [7:0]  byteIn,
  output logic [31:0] word,
  output logic [7:0]  checksum,
  output logic        lastByte
);

  logic [1:0] byteCnt;

  // Word-complete flag: three bytes already held, so the next one finishes the word.
  assign lastByte = (byteCnt == 2'd3);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      word     <= '0;
      byteCnt  <= '0;
      checksum <= '0;
    end else if (clear) begin
      // The word register is left alone; it is fully overwritten before its next use.
      byteCnt  <= '0;
      checksum <= '0;
    end else if (shiftEn) begin
      word     <= {word[23:0], byteIn};
      byteCnt  <= byteCnt + 2'd1;
      checksum <= checksum ^ byteIn;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Framed byte-stream loader writing 32-bit big-endian words into instruction memory from address 0.
// Latency: ImWe one cycle after the 4th byte of a word is accepted; 5 cycles per word with ByteValid held.
// Backpressure: ByteReady low during WRITE, DONE and ERR; bytes are consumed only on ByteValid && ByteReady.
// Ports: Clk, Reset (async active-low); ByteIn/ByteValid/ByteReady host byte handshake;
// Restart re-arms from DONE/ERR; ImWe/ImWAdr/ImWData memory write port; CpuHold holds
// the core in reset until a clean load; Done/Error report the last frame's outcome.
module im_loader
  import mips_pkg::*;
#(
  parameter int         DEPTH = 32,
  parameter int         AW    = 5,
  parameter logic [7:0] SYNC  = SYNC_BYTE
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [7:0]    ByteIn,
  input  logic          ByteValid,
  output logic          ByteReady,
  input  logic          Restart,
  output logic          ImWe,
  output logic [AW-1:0] ImWAdr,
  output logic [31:0]   ImWData,
  output logic          CpuHold,
  output logic          Done,
  output logic          Error
);

  localparam logic [8:0] DEPTH9 = 9'(DEPTH);

  loadState_t    state, nextState;
  logic          accept;
  logic          packClear;
  logic          packShift;
  logic [AW-1:0] wordCnt;
  logic [AW-1:0] lastIdx;   // N-1, so N==DEPTH still fits in AW bits
  logic [31:0]   packWord;
  logic [7:0]    checksum;
  logic          lastByte;

  im_word_packer uPacker (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (packClear),
    .shiftEn  (packShift),
    .byteIn   (ByteIn),
    .word     (packWord),
    .checksum (checksum),
    .lastByte (lastByte)
  );

  // All outputs are decodes of registered state, never of ByteIn/ByteValid.
  assign ByteReady = (state inside {IDLE, LEN, DATA, CHECK});
  assign ImWe      = (state == WRITE);
  assign ImWAdr    = wordCnt;
  assign ImWData   = packWord;
  assign Done      = (state == DONE);
  assign Error     = (state == ERR);
  assign CpuHold   = (state != DONE);
  assign accept    = ByteValid && ByteReady;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    packClear = 1'b0;
    packShift = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (ByteIn == SYNC)) nextState = LEN;
      end
      LEN: begin
        if (accept) begin
          if ((ByteIn == 8'd0) || ({1'b0, ByteIn} > DEPTH9)) begin
            nextState = ERR;
          end else begin
            nextState = DATA;
            packClear = 1'b1;
          end
        end
      end
      DATA: begin
        if (accept) begin
          packShift = 1'b1;
          if (lastByte) nextState = WRITE;
        end
      end
      WRITE: begin
        nextState = (wordCnt == lastIdx) ? CHECK : DATA;
      end
      CHECK: begin
        if (accept) nextState = (ByteIn == checksum) ? DONE : ERR;
      end
      DONE, ERR: begin
        if (Restart) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wordCnt <= '0;
      lastIdx <= '0;
    end else if (packClear) begin
      wordCnt <= '0;
      lastIdx <= AW'(ByteIn - 8'd1);
    end else if ((state == WRITE) && (wordCnt != lastIdx)) begin
      // The counter stops on the final word instead of stepping past DEPTH-1.
      wordCnt <= wordCnt + AW'(1);
    end
  end

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;

  localparam int AW = 5;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic [7:0]    ByteIn = 8'h00;
  logic          ByteValid = 1'b0;
  logic          Restart = 1'b0;
  logic          ByteReady, ImWe, CpuHold, Done, Error;
  logic [AW-1:0] ImWAdr;
  logic [31:0]   ImWData;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          wrAdr[$];
  logic [31:0] wrDat[$];
  int          wrCyc[$];
  logic [7:0]  txQ[$];
  logic [31:0] expWords[$];
  bit          expDone;

  im_loader #(.DEPTH(32), .AW(AW), .SYNC(8'hA5)) dut (
    .Clk(Clk), .Reset(Reset), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ByteReady), .Restart(Restart), .ImWe(ImWe), .ImWAdr(ImWAdr),
    .ImWData(ImWData), .CpuHold(CpuHold), .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  // Write capture: every cycle with ImWe high is one memory write; the loader
  // must not take bytes during it.
  always @(negedge Clk) begin
    if (ImWe === 1'b1) begin
      wrAdr.push_back(int'(ImWAdr));
      wrDat.push_back(ImWData);
      wrCyc.push_back(cyc);
      checks++;
      if (ByteReady !== 1'b0) begin
        errors++;
        $display("FAIL readyDuringWrite ByteReady=%b expected 0", ByteReady);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  function automatic void clearCapture();
    wrAdr.delete(); wrDat.delete(); wrCyc.delete();
  endfunction

  // Reference frame: SYNC, N, 4N payload bytes MSB first, XOR of payload (optionally off by one).
  function automatic void buildFrame(int n, bit corrupt);
    logic [7:0]  sum;
    logic [31:0] w;
    sum = 8'h00;
    txQ.delete(); expWords.delete();
    txQ.push_back(8'hA5);
    txQ.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      expWords.push_back(w);
      for (int b = 3; b >= 0; b--) begin
        txQ.push_back(w[8*b +: 8]);
        sum ^= w[8*b +: 8];
      end
    end
    txQ.push_back(corrupt ? sum + 8'd1 : sum);
    expDone = !corrupt;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic sendByte(input logic [7:0] b, input int maxGap);
    int g;
    int guard;
    g = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
    guard = 0;
    repeat (g) begin
      ByteValid = 1'b0;
      @(negedge Clk);
    end
    ByteValid = 1'b1;
    ByteIn = b;
    while (ByteReady !== 1'b1 && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    if (ByteReady !== 1'b1) begin
      checks++; errors++;
      $display("FAIL byteTimeout ByteReady=%b expected 1 within 20 cycles", ByteReady);
    end
    @(negedge Clk);
    ByteValid = 1'b0;
  endtask

  task automatic sendRange(input int first, input int last, input int maxGap);
    for (int i = first; i <= last; i++) sendByte(txQ[i], maxGap);
  endtask

  task automatic pulseRestart();
    Restart = 1'b1;
    @(negedge Clk);
    Restart = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    checks++;
    if ({ByteReady, ImWe, CpuHold, Done, Error, ImWAdr, ImWData} !== {5'b10100, 5'd0, 32'd0}) begin
      errors++;
      $display("FAIL resetState rdy/we/hold/done/err=%b%b%b%b%b adr=%0d dat=%h expected 10100 0 0",
               ByteReady, ImWe, CpuHold, Done, Error, ImWAdr, ImWData);
    end
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_nominal();
    logic [7:0] f[7];
    f = '{8'hA5, 8'h01, 8'h20, 8'h01, 8'h00, 8'h05, 8'h24};
    clearCapture();
    for (int i = 0; i < 6; i++) sendByte(f[i], 0);
    checks++;
    if ({ImWe, ImWAdr, ImWData} !== {1'b1, 5'd0, 32'h20010005}) begin
      errors++;
      $display("FAIL nominalWrite we=%b adr=%0d dat=%h expected 1 0 20010005", ImWe, ImWAdr, ImWData);
    end
    checks++;
    if (CpuHold !== 1'b1) begin
      errors++; $display("FAIL nominalHoldBefore CpuHold=%b expected 1", CpuHold);
    end
    sendByte(f[6], 0);
    checks++;
    if ({Done, CpuHold, Error} !== 3'b100) begin
      errors++; $display("FAIL nominalDone done/hold/err=%b%b%b expected 100", Done, CpuHold, Error);
    end
    checks++;
    if (wrAdr.size() != 1) begin
      errors++; $display("FAIL nominalWriteCount got %0d expected 1", wrAdr.size());
    end
    pulseRestart();
  endtask

  task automatic test_bad_length();
    logic [7:0] lens[2];
    lens = '{8'h00, 8'h21};
    foreach (lens[k]) begin
      clearCapture();
      sendByte(8'hA5, 0);
      sendByte(lens[k], 0);
      checks++;
      if ({Error, CpuHold, Done, ByteReady} !== 4'b1100) begin
        errors++;
        $display("FAIL badLen%0d err/hold/done/rdy=%b%b%b%b expected 1100", lens[k], Error, CpuHold, Done, ByteReady);
      end
      repeat (3) @(negedge Clk);
      checks++;
      if (wrAdr.size() != 0) begin
        errors++; $display("FAIL badLenWrites%0d got %0d writes expected 0", lens[k], wrAdr.size());
      end
      pulseRestart();
      checks++;
      if ({Error, CpuHold, ByteReady} !== 3'b011) begin
        errors++; $display("FAIL badLenRestart err/hold/rdy=%b%b%b expected 011", Error, CpuHold, ByteReady);
      end
    end
  endtask

  task automatic test_checksum_mismatch();
    clearCapture();
    buildFrame(2, 1'b1);
    sendRange(0, txQ.size() - 1, 0);
    checks++;
    if (wrAdr.size() != 2) begin
      errors++; $display("FAIL mismatchWriteCount got %0d expected 2", wrAdr.size());
    end
    for (int i = 0; i < wrAdr.size() && i < 2; i++) begin
      checks++;
      if (wrAdr[i] != i || wrDat[i] !== expWords[i]) begin
        errors++;
        $display("FAIL mismatchWrite%0d adr=%0d dat=%h expected %0d %h", i, wrAdr[i], wrDat[i], i, expWords[i]);
      end
    end
    checks++;
    if ({Error, CpuHold, Done} !== 3'b110) begin
      errors++; $display("FAIL mismatchStatus err/hold/done=%b%b%b expected 110", Error, CpuHold, Done);
    end
    pulseRestart();
  endtask

  task automatic test_noise_backpressure();
    logic [7:0] noise[3];
    noise = '{8'h00, 8'hFF, 8'h3C};
    clearCapture();
    foreach (noise[k]) sendByte(noise[k], 2);
    buildFrame(32, 1'b0);
    sendRange(0, txQ.size() - 1, 2);
    checks++;
    if (wrAdr.size() != 32) begin
      errors++; $display("FAIL noiseWriteCount got %0d expected 32", wrAdr.size());
    end
    for (int i = 0; i < wrAdr.size() && i < 32; i++) begin
      checks++;
      if (wrAdr[i] != i || wrDat[i] !== expWords[i]) begin
        errors++;
        $display("FAIL noiseWrite%0d adr=%0d dat=%h expected %0d %h", i, wrAdr[i], wrDat[i], i, expWords[i]);
      end
    end
    checks++;
    if ({Done, CpuHold, Error} !== {expDone, !expDone, 1'b0}) begin
      errors++; $display("FAIL noiseStatus done/hold/err=%b%b%b expected 100", Done, CpuHold, Error);
    end
    pulseRestart();
  endtask

  task automatic test_back_to_back();
    clearCapture();
    buildFrame(4, 1'b0);
    sendRange(0, txQ.size() - 1, 0);
    checks++;
    if (wrCyc.size() != 4 || (wrCyc[3] - wrCyc[0]) != 15) begin
      errors++;
      $display("FAIL wordSpacing writes=%0d span=%0d expected 4 writes span 15", wrCyc.size(),
               (wrCyc.size() == 4) ? wrCyc[3] - wrCyc[0] : -1);
    end
    for (int i = 0; i < wrAdr.size() && i < 4; i++) begin
      checks++;
      if (wrAdr[i] != i || wrDat[i] !== expWords[i]) begin
        errors++;
        $display("FAIL b2bWrite%0d adr=%0d dat=%h expected %0d %h", i, wrAdr[i], wrDat[i], i, expWords[i]);
      end
    end
    checks++;
    if (Done !== 1'b1) begin
      errors++; $display("FAIL b2bDone Done=%b expected 1", Done);
    end
    pulseRestart();
  endtask

  task automatic test_reset_mid();
    clearCapture();
    buildFrame(4, 1'b0);
    // SYNC, N, words 0..2, then the first two bytes of word 3
    sendRange(0, 15, 0);
    #2 Reset = 1'b0;
    #1;
    checks++;
    if ({ByteReady, ImWe, CpuHold, Done, Error, ImWAdr, ImWData} !== {5'b10100, 5'd0, 32'd0}) begin
      errors++;
      $display("FAIL midReset rdy/we/hold/done/err=%b%b%b%b%b adr=%0d dat=%h expected 10100 0 0",
               ByteReady, ImWe, CpuHold, Done, Error, ImWAdr, ImWData);
    end
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if (wrAdr.size() != 3) begin
      errors++; $display("FAIL midResetWrites got %0d writes expected 3 (no address 3)", wrAdr.size());
    end
    clearCapture();
    buildFrame(3, 1'b0);
    sendRange(0, txQ.size() - 1, 1);
    checks++;
    if (wrAdr.size() != 3) begin
      errors++; $display("FAIL reloadWriteCount got %0d expected 3", wrAdr.size());
    end
    for (int i = 0; i < wrAdr.size() && i < 3; i++) begin
      checks++;
      if (wrAdr[i] != i || wrDat[i] !== expWords[i]) begin
        errors++;
        $display("FAIL reloadWrite%0d adr=%0d dat=%h expected %0d %h", i, wrAdr[i], wrDat[i], i, expWords[i]);
      end
    end
    checks++;
    if ({Done, CpuHold} !== 2'b10) begin
      errors++; $display("FAIL reloadDone done/hold=%b%b expected 10", Done, CpuHold);
    end
  endtask

  task automatic test_restart();
    // Entered from DONE.
    pulseRestart();
    checks++;
    if ({CpuHold, Done, Error, ByteReady} !== 4'b1001) begin
      errors++;
      $display("FAIL restartFromDone hold/done/err/rdy=%b%b%b%b expected 1001", CpuHold, Done, Error, ByteReady);
    end
    clearCapture();
    buildFrame(3, 1'b0);
    sendRange(0, 7, 0);
    pulseRestart();
    sendRange(8, txQ.size() - 1, 0);
    checks++;
    if (wrAdr.size() != 3) begin
      errors++; $display("FAIL restartIgnoredWrites got %0d expected 3", wrAdr.size());
    end
    for (int i = 0; i < wrAdr.size() && i < 3; i++) begin
      checks++;
      if (wrAdr[i] != i || wrDat[i] !== expWords[i]) begin
        errors++;
        $display("FAIL restartWrite%0d adr=%0d dat=%h expected %0d %h", i, wrAdr[i], wrDat[i], i, expWords[i]);
      end
    end
    checks++;
    if ({Done, CpuHold} !== 2'b10) begin
      errors++; $display("FAIL restartIgnoredDone done/hold=%b%b expected 10", Done, CpuHold);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_length();
    test_checksum_mismatch();
    test_noise_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
